alu8_seq_driver: RTL and testbench
==================================

Name: alu8_seq_driver

Overview:
- Initiator side of the 4-bit combinational ALU. Accepts 8-bit commands on a valid/ready request port and drives the external 4-bit ALU one nibble pass per cycle.
- Consumes the ALU's y/carry/overflow/equal outputs and assembles 8-bit results plus flags.
- Returns the result on a valid/ready response port.
- Sits between the command source and one 4-bit ALU instance.

Parameters:
- STAT_W, 16, width of the completed-command counter; used only with ALU8_DRV_STATS_EN.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when high together with req_valid
- req_a  in  8  operand A
- req_b  in  8  operand B
- req_op  in  3  000 add, 001 sub, 010 not(a), 011 and, 100 or, 101 xor, 110 unsigned a<b, 111 a==b
- alu_a  out  4  ALU operand A nibble
- alu_b  out  4  ALU operand B nibble
- alu_op  out  3  ALU opcode (same encoding, 4-bit)
- alu_y  in  4  ALU result
- alu_carry  in  1  add: carry-out; sub: 1 = no borrow
- alu_overflow  in  1  ALU signed overflow (unused internally)
- alu_equal  in  1  result of op 110/111
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_y  out  8  result; 0 for 110/111
- rsp_carry  out  1  add/sub only, else 0
- rsp_overflow  out  1  8-bit signed overflow, add/sub only, else 0
- rsp_zero  out  1  add/sub: rsp_y==0; else 0
- rsp_flag  out  1  110/111 result; else 0

Behaviour:
- Reset: async, active-low; one clock (clk). State IDLE. req_ready=1, rsp_valid=0, all rsp_* = 0, alu_* = 0. Reset mid-command aborts it; the command is lost.
- States: IDLE, PASS1, PASS2, PASS3, RESP.
- IDLE:
  - req_ready = (state==IDLE).
  - On req_valid&req_ready: latch a, b, op; go to PASS1.
- PASS states:
  - alu_* are combinational from state and latched operands.
  - ALU outputs are sampled at the end of the same cycle: one cycle per pass.
  - In IDLE/RESP, alu_* = 0.
- Latency: the number of cycles from the accept edge to rsp_valid rising equals the number of passes.
- Add:
  - P1 lo: a_lo+b_lo, gives y_lo and c0.
  - P2 hi: a_hi+b_hi, gives t and c1.
  - If c0: P3 hi+0001 (op 000), giving y_hi and c2; carry = c1|c2. Else y_hi = t and carry = c1.
- Sub:
  - P1 lo: a_lo-b_lo (op 001), gives c0.
  - P2 hi: a_hi-b_hi, gives t and c1.
  - If !c0: P3 t-0001, giving c2; carry = c1&c2. Else carry = c1.
- Overflow (computed in the driver):
  - add: a7==b7 && y7!=a7.
  - sub: a7!=b7 && y7!=a7.
- Logic ops 010–101: P1 lo, P2 hi, same op; flags 0.
- 110 (a<b):
  - P1 hi op110: if 1, flag=1, done.
  - P2 hi op111: if 0, flag=0, done.
  - P3 lo op110: flag = result.
- 111 (a==b):
  - P1 lo op111: if 0, flag=0, done.
  - P2 hi op111: flag = result.
- RESP:
  - rsp_* registered and held stable while rsp_valid && !rsp_ready.
  - On rsp_ready: go to IDLE and clear rsp_valid. req_ready is high the following cycle; no same-cycle accept.
- All 8 opcodes are defined; there is no illegal-op state. The default FSM branch returns to IDLE.

Optional Feature:
- ALU8_DRV_STATS_EN defined:
  - Adds output port cmd_count [STAT_W-1:0].
  - Reset 0; increments on each rsp handshake; wraps at 2^STAT_W.
- Undefined: no port, no counter logic.

Test Plan:
- ADD 0x0F+0x01 -> 3 passes; rsp_y=0x10, carry=0, overflow=0, zero=0. ADD 0x80+0x80 -> 2 passes; rsp_y=0x00, carry=1, overflow=1, zero=1.
- SUB 0x00-0x01 -> 3 passes; rsp_y=0xFF, carry=0, overflow=0. SUB 0x10-0x01 -> 3 passes; rsp_y=0x0F, carry=1. SUB 0x80-0x01 -> rsp_y=0x7F, overflow=1.
- LT 0x35 vs 0x3A -> 3 passes, flag=1. LT 0x50 vs 0x3F -> 2 passes, flag=0. EQ 0xA5 vs 0xA4 -> 1 pass, flag=0, rsp_y=0.
- XOR 0xF0^0x3C -> 2 passes; rsp_y=0xCC, carry/overflow/zero/flag all 0. Check alu_a/alu_b/alu_op per cycle: (0x0,0xC,101) then (0xF,0x3,101).
- Backpressure: rsp_ready low for 5 cycles -> rsp_* stable, req_ready=0. Raise rsp_ready -> rsp_valid drops next edge, then req_ready=1.
- Assert rst_n low during PASS2 of an add -> all outputs 0 immediately, req_ready=1. A new command after release completes correctly. With the macro enabled, cmd_count returns to 0.

Source files
------------

// File: rtl/alu8_seq_driver.sv
// 8-bit command driver for a 4-bit combinational ALU: sequences nibble passes and assembles results/flags.
// Optional ALU8_DRV_STATS_EN adds a cmd_count output counting completed response handshakes.
module alu8_seq_driver #(
    parameter int STAT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic [2:0] req_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_y,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  logic       alu_equal,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_y,
    output logic       rsp_carry,
    output logic       rsp_overflow,
    output logic       rsp_zero,
    output logic       rsp_flag
`ifdef ALU8_DRV_STATS_EN
    ,
    output logic [STAT_W-1:0] cmd_count
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PASS1 = 3'd1,
        PASS2 = 3'd2,
        PASS3 = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [2:0]  op_r;
    logic [3:0]  y_lo_r;
    logic [3:0]  t_r;
    logic        c0_r;
    logic        c1_r;
    logic        accept_s;
    logic        rsp_hs_s;
    logic        fin_s;
    logic [7:0]  fin_y_s;
    logic        fin_carry_s;
    logic        fin_flag_s;
    logic        fin_ovf_s;
    logic        fin_zero_s;
    logic        arith_s;
    logic        unused_s;

    // 8-bit signed overflow from operand and result sign bits
    function automatic logic signed_ovf(input logic [2:0] op, input logic a7,
                                        input logic b7, input logic y7);
        logic ovf;
        if (op == OP_ADD) begin
            ovf = (a7 == b7) && (y7 != a7);
        end else if (op == OP_SUB) begin
            ovf = (a7 != b7) && (y7 != a7);
        end else begin
            ovf = 1'b0;
        end
        return ovf;
    endfunction

    assign unused_s  = alu_overflow;
    assign req_ready = (state_r == IDLE);
    assign accept_s  = req_valid && req_ready;
    assign rsp_hs_s  = (state_r == RESP) && rsp_ready;
    assign arith_s   = (op_r == OP_ADD) || (op_r == OP_SUB);
    assign fin_ovf_s  = signed_ovf(op_r, a_r[7], b_r[7], fin_y_s[7]);
    assign fin_zero_s = arith_s && (fin_y_s == 8'h00);

    // ALU drive: a < b starts on the high nibble; the third add/sub pass fixes up the high nibble by one
    always_comb begin
        alu_a  = 4'h0;
        alu_b  = 4'h0;
        alu_op = 3'b000;
        case (state_r)
            PASS1: begin
                if (op_r == OP_LT) begin
                    alu_a  = a_r[7:4];
                    alu_b  = b_r[7:4];
                    alu_op = OP_LT;
                end else begin
                    alu_a  = a_r[3:0];
                    alu_b  = b_r[3:0];
                    alu_op = op_r;
                end
            end
            PASS2: begin
                alu_a  = a_r[7:4];
                alu_b  = b_r[7:4];
                alu_op = (op_r == OP_LT) ? OP_EQ : op_r;
            end
            PASS3: begin
                if (op_r == OP_LT) begin
                    alu_a  = a_r[3:0];
                    alu_b  = b_r[3:0];
                    alu_op = OP_LT;
                end else begin
                    alu_a  = t_r;
                    alu_b  = 4'h1;
                    alu_op = op_r;
                end
            end
            default: begin
                alu_a  = 4'h0;
                alu_b  = 4'h0;
                alu_op = 3'b000;
            end
        endcase
    end

    // Next state and final-pass result assembly
    always_comb begin
        state_next_s = state_r;
        fin_s        = 1'b0;
        fin_y_s      = 8'h00;
        fin_carry_s  = 1'b0;
        fin_flag_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = PASS1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PASS1: begin
                if ((op_r == OP_LT) && alu_equal) begin
                    fin_s      = 1'b1;
                    fin_flag_s = 1'b1;
                end else if ((op_r == OP_EQ) && !alu_equal) begin
                    fin_s = 1'b1;
                end else begin
                    state_next_s = PASS2;
                end
            end
            PASS2: begin
                case (op_r)
                    OP_ADD, OP_SUB: begin
                        // a carry out of the add low nibble, or a borrow in the sub, needs a fix-up pass
                        if ((op_r == OP_ADD) == c0_r) begin
                            state_next_s = PASS3;
                        end else begin
                            fin_s       = 1'b1;
                            fin_y_s     = {alu_y, y_lo_r};
                            fin_carry_s = alu_carry;
                        end
                    end
                    OP_LT: begin
                        if (alu_equal) begin
                            state_next_s = PASS3;
                        end else begin
                            fin_s = 1'b1;
                        end
                    end
                    OP_EQ: begin
                        fin_s      = 1'b1;
                        fin_flag_s = alu_equal;
                    end
                    default: begin
                        fin_s   = 1'b1;
                        fin_y_s = {alu_y, y_lo_r};
                    end
                endcase
            end
            PASS3: begin
                fin_s = 1'b1;
                case (op_r)
                    OP_ADD: begin
                        fin_y_s     = {alu_y, y_lo_r};
                        fin_carry_s = c1_r | alu_carry;
                    end
                    OP_SUB: begin
                        fin_y_s     = {alu_y, y_lo_r};
                        fin_carry_s = c1_r & alu_carry;
                    end
                    OP_LT: begin
                        fin_flag_s = alu_equal;
                    end
                    default: begin
                        fin_y_s = 8'h00;
                    end
                endcase
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        if (fin_s) begin
            state_next_s = RESP;
        end else begin
            fin_y_s = fin_y_s;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Command latch and per-pass partial results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= 8'h00;
            b_r    <= 8'h00;
            op_r   <= 3'b000;
            y_lo_r <= 4'h0;
            t_r    <= 4'h0;
            c0_r   <= 1'b0;
            c1_r   <= 1'b0;
        end else if (accept_s) begin
            a_r  <= req_a;
            b_r  <= req_b;
            op_r <= req_op;
        end else if (state_r == PASS1) begin
            y_lo_r <= alu_y;
            c0_r   <= alu_carry;
        end else if (state_r == PASS2) begin
            t_r  <= alu_y;
            c1_r <= alu_carry;
        end
    end

    // Response registers, held until the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid    <= 1'b0;
            rsp_y        <= 8'h00;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_flag     <= 1'b0;
        end else if (fin_s) begin
            rsp_valid    <= 1'b1;
            rsp_y        <= fin_y_s;
            rsp_carry    <= fin_carry_s;
            rsp_overflow <= fin_ovf_s;
            rsp_zero     <= fin_zero_s;
            rsp_flag     <= fin_flag_s;
        end else if (rsp_hs_s) begin
            rsp_valid    <= 1'b0;
            rsp_y        <= 8'h00;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_flag     <= 1'b0;
        end
    end

`ifdef ALU8_DRV_STATS_EN
    // Completed-command counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_count <= '0;
        end else if (rsp_hs_s) begin
            cmd_count <= cmd_count + {{(STAT_W-1){1'b0}}, 1'b1};
        end
    end
`else
    localparam int unused_stat_w = STAT_W;
`endif

endmodule

// File: tb/tb_alu8_seq_driver.sv
// Directed bench for alu8_seq_driver with a behavioural 4-bit ALU attached to its alu_* port.
module tb_alu8_seq_driver;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [2:0] req_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_y;
    logic       alu_carry;
    logic       alu_overflow;
    logic       alu_equal;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_y;
    logic       rsp_carry;
    logic       rsp_overflow;
    logic       rsp_zero;
    logic       rsp_flag;
`ifdef ALU8_DRV_STATS_EN
    logic [15:0] cmd_count;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        int         passes;
        logic [7:0] y;
        logic       c;
        logic       o;
        logic       z;
        logic       f;
    } vec_t;

    alu8_seq_driver dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .alu_equal(alu_equal),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_carry(rsp_carry),
        .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .rsp_flag(rsp_flag)
`ifdef ALU8_DRV_STATS_EN
        , .cmd_count(cmd_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 4-bit ALU
    always_comb begin
        alu_y        = 4'h0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        alu_equal    = 1'b0;
        case (alu_op)
            3'b000: begin
                {alu_carry, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
                alu_overflow = (alu_a[3] == alu_b[3]) && (alu_y[3] != alu_a[3]);
            end
            3'b001: begin
                alu_y     = alu_a - alu_b;
                alu_carry = (alu_a >= alu_b);
                alu_overflow = (alu_a[3] != alu_b[3]) && (alu_y[3] != alu_a[3]);
            end
            3'b010:  alu_y = ~alu_a;
            3'b011:  alu_y = alu_a & alu_b;
            3'b100:  alu_y = alu_a | alu_b;
            3'b101:  alu_y = alu_a ^ alu_b;
            3'b110:  alu_equal = (alu_a < alu_b);
            default: alu_equal = (alu_a == alu_b);
        endcase
    end

    // Issue one command (rsp_ready high) and report latency and response; lat=-1 on timeout
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           output int lat, output logic [7:0] y, output logic c,
                           output logic o, output logic z, output logic f);
        int n;
        lat = -1; y = 8'h00; c = 1'b0; o = 1'b0; z = 1'b0; f = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        rsp_ready = 1'b1;
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (lat < 0 && n < 8) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (rsp_valid === 1'b1) begin
                lat = n;
                y = rsp_y; c = rsp_carry; o = rsp_overflow; z = rsp_zero; f = rsp_flag;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
        end
        checks++;
        if ({rsp_y, rsp_carry, rsp_overflow, rsp_zero, rsp_flag} !== 12'h000) begin
            failures++;
            $display("FAIL reset_rsp: y=%h c=%b o=%b z=%b f=%b want all 0",
                     rsp_y, rsp_carry, rsp_overflow, rsp_zero, rsp_flag);
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== 11'h000) begin
            failures++;
            $display("FAIL reset_alu: a=%h b=%h op=%b want 0", alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_arith();
        vec_t v [9];
        int lat;
        logic [7:0] y;
        logic c, o, z, f;
        v[0] = '{8'h0F, 8'h01, 3'b000, 3, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
        v[1] = '{8'h80, 8'h80, 3'b000, 2, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        v[2] = '{8'h00, 8'h01, 3'b001, 3, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
        v[3] = '{8'h10, 8'h01, 3'b001, 3, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0};
        v[4] = '{8'h80, 8'h01, 3'b001, 3, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
        v[5] = '{8'h7F, 8'h01, 3'b000, 3, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0};
        v[6] = '{8'h35, 8'h12, 3'b001, 2, 8'h23, 1'b1, 1'b0, 1'b0, 1'b0};
        v[7] = '{8'h5A, 8'h5A, 3'b001, 2, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        v[8] = '{8'hFF, 8'h01, 3'b000, 3, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            run_cmd(v[i].a, v[i].b, v[i].op, lat, y, c, o, z, f);
            checks++;
            if (lat != v[i].passes) begin
                failures++;
                $display("FAIL arith_lat[%0d]: got %0d want %0d", i, lat, v[i].passes);
            end
            checks++;
            if ({y, c, o, z, f} !== {v[i].y, v[i].c, v[i].o, v[i].z, v[i].f}) begin
                failures++;
                $display("FAIL arith_rsp[%0d]: y=%h c=%b o=%b z=%b f=%b want y=%h c=%b o=%b z=%b f=%b",
                         i, y, c, o, z, f, v[i].y, v[i].c, v[i].o, v[i].z, v[i].f);
            end
        end
    endtask

    task automatic test_compare_logic();
        vec_t v [11];
        int lat;
        logic [7:0] y;
        logic c, o, z, f;
        v[0]  = '{8'h35, 8'h3A, 3'b110, 3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        v[1]  = '{8'h50, 8'h3F, 3'b110, 2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        v[2]  = '{8'h20, 8'h30, 3'b110, 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        v[3]  = '{8'h3A, 8'h35, 3'b110, 3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        v[4]  = '{8'hA5, 8'hA4, 3'b111, 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        v[5]  = '{8'hA5, 8'hA5, 3'b111, 2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        v[6]  = '{8'h15, 8'h25, 3'b111, 2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        v[7]  = '{8'hF0, 8'h3C, 3'b011, 2, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        v[8]  = '{8'hF0, 8'h0C, 3'b100, 2, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0};
        v[9]  = '{8'h5A, 8'hFF, 3'b010, 2, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        v[10] = '{8'h55, 8'h55, 3'b101, 2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            run_cmd(v[i].a, v[i].b, v[i].op, lat, y, c, o, z, f);
            checks++;
            if (lat != v[i].passes) begin
                failures++;
                $display("FAIL cmp_lat[%0d]: got %0d want %0d", i, lat, v[i].passes);
            end
            checks++;
            if ({y, c, o, z, f} !== {v[i].y, v[i].c, v[i].o, v[i].z, v[i].f}) begin
                failures++;
                $display("FAIL cmp_rsp[%0d]: y=%h c=%b o=%b z=%b f=%b want y=%h c=%b o=%b z=%b f=%b",
                         i, y, c, o, z, f, v[i].y, v[i].c, v[i].o, v[i].z, v[i].f);
            end
        end
    endtask

    task automatic test_xor_trace();
        rsp_ready = 1'b1;
        req_a = 8'hF0; req_b = 8'h3C; req_op = 3'b101; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({alu_a, alu_b, alu_op} !== {4'h0, 4'hC, 3'b101}) begin
            failures++;
            $display("FAIL xor_pass1: a=%h b=%h op=%b want 0 c 101", alu_a, alu_b, alu_op);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({alu_a, alu_b, alu_op, rsp_valid} !== {4'hF, 4'h3, 3'b101, 1'b0}) begin
            failures++;
            $display("FAIL xor_pass2: a=%h b=%h op=%b rv=%b want f 3 101 0", alu_a, alu_b, alu_op, rsp_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_y, rsp_carry, rsp_overflow, rsp_zero, rsp_flag} !== {1'b1, 8'hCC, 4'h0}) begin
            failures++;
            $display("FAIL xor_rsp: rv=%b y=%h c=%b o=%b z=%b f=%b want 1 cc 0 0 0 0",
                     rsp_valid, rsp_y, rsp_carry, rsp_overflow, rsp_zero, rsp_flag);
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== 11'h000) begin
            failures++;
            $display("FAIL xor_resp_alu: a=%h b=%h op=%b want 0", alu_a, alu_b, alu_op);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int n;
        rsp_ready = 1'b0;
        req_a = 8'h12; req_b = 8'h34; req_op = 3'b000; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_timeout: rsp_valid=%b after %0d cycles want 1", rsp_valid, n);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_y, req_ready} !== {1'b1, 8'h46, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold[%0d]: rv=%b y=%h rr=%b want 1 46 0", i, rsp_valid, rsp_y, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_release: rv=%b rr=%b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_midcmd();
        int lat;
        logic [7:0] y;
        logic c, o, z, f;
        rsp_ready = 1'b1;
        req_a = 8'h3F; req_b = 8'h21; req_op = 3'b000; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({alu_a, alu_b, alu_op} !== {4'h3, 4'h2, 3'b000}) begin
            failures++;
            $display("FAIL rst_pass2: a=%h b=%h op=%b want 3 2 000", alu_a, alu_b, alu_op);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_op, rsp_valid, rsp_y, req_ready} !== {11'h000, 1'b0, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL rst_async: a=%h b=%h op=%b rv=%b y=%h rr=%b want 0 0 0 0 00 1",
                     alu_a, alu_b, alu_op, rsp_valid, rsp_y, req_ready);
        end
`ifdef ALU8_DRV_STATS_EN
        checks++;
        if (cmd_count !== 16'h0000) begin
            failures++;
            $display("FAIL rst_count: got %0d want 0", cmd_count);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_cmd(8'h80, 8'h80, 3'b000, lat, y, c, o, z, f);
        checks++;
        if (lat != 2 || {y, c, o, z} !== {8'h00, 1'b1, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL rst_after: lat=%0d y=%h c=%b o=%b z=%b want 2 00 1 1 1", lat, y, c, o, z);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_a = 8'h00; req_b = 8'h00; req_op = 3'b000;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_arith();
        test_compare_logic();
        test_xor_trace();
        test_backpressure();
        test_reset_midcmd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
